// File: rtl/clock_gen_4201.sv
// Two-phase non-overlapping clock generator (clk1/clk2) with power-on clear
// and single-instruction-cycle stepping keyed off the CPU sync marker.
module clock_gen_4201 #(
  parameter int CLK_W       = 3,
  parameter int GAP_W       = 1,
  parameter int POC_PERIODS = 64
) (
  input  logic sysclk,
  input  logic reset,
  input  logic step_mode,
  input  logic step,
  input  logic sync,
  output logic clk1_pad,
  output logic clk2_pad,
  output logic poc_pad,
  output logic halted,
  output logic period_end
);

  localparam int         PERIOD     = 2 * (CLK_W + GAP_W);
  localparam logic [4:0] CNT_LAST   = 5'(PERIOD - 1);
  localparam logic [4:0] CLK1_STOP  = 5'(CLK_W);
  localparam logic [4:0] CLK2_START = 5'(CLK_W + GAP_W);
  localparam logic [4:0] CLK2_STOP  = 5'(2 * CLK_W + GAP_W);
  localparam logic [7:0] POC_LAST   = 8'(POC_PERIODS - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ARMED = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] cnt;
  logic [4:0] cnt_next;
  logic [4:0] cnt_inc;
  logic       step_prev;
  logic       step_rise;
  logic       running;
  logic       clk1_next;
  logic       clk2_next;
  logic       end_next;
  logic [7:0] poc_cnt;

  // Next-state, phase counter and decoded phase outputs
  always_comb begin
    state_next = state;
    cnt_inc    = (cnt == CNT_LAST) ? 5'd0 : cnt + 5'd1;
    cnt_next   = cnt_inc;
    step_rise  = step & ~step_prev;
    running    = 1'b0;
    case (state)
      RUN: begin
        running = 1'b1;
        // Arm only on clk2 rising of the sync period, never during power-on clear
        if ((cnt == CLK2_START) && sync && step_mode && !poc_pad) begin
          state_next = ARMED;
        end else begin
          state_next = RUN;
        end
      end
      ARMED: begin
        running = 1'b1;
        if (!step_mode) begin
          state_next = RUN;
        end else if (cnt == CNT_LAST) begin
          state_next = HALT;
        end else begin
          state_next = ARMED;
        end
      end
      HALT: begin
        cnt_next = 5'd0;
        if (step_rise || !step_mode) begin
          state_next = RUN;
        end else begin
          state_next = HALT;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 5'd0;
      end
    endcase
    clk1_next = running && (cnt < CLK1_STOP);
    clk2_next = running && (cnt >= CLK2_START) && (cnt < CLK2_STOP);
    end_next  = running && (cnt == CNT_LAST);
  end

  // State, counter, step history and registered pad outputs
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= RUN;
      cnt        <= 5'd0;
      step_prev  <= 1'b1;
      clk1_pad   <= 1'b0;
      clk2_pad   <= 1'b0;
      period_end <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      step_prev  <= step;
      clk1_pad   <= clk1_next;
      clk2_pad   <= clk2_next;
      period_end <= end_next;
      halted     <= (state == HALT);
    end
  end

  // Power-on clear: hold poc_pad for POC_PERIODS completed clock periods
  always_ff @(posedge sysclk) begin
    if (reset) begin
      poc_pad <= 1'b1;
      poc_cnt <= 8'd0;
    end else if (poc_pad && period_end) begin
      poc_cnt <= poc_cnt + 8'd1;
      if (poc_cnt == POC_LAST) begin
        poc_pad <= 1'b0;
      end else begin
        poc_pad <= 1'b1;
      end
    end else begin
      poc_pad <= poc_pad;
      poc_cnt <= poc_cnt;
    end
  end

endmodule

// File: tb/tb_clock_gen_4201.sv
// Randomized bench for clock_gen_4201 over several CLK_W/GAP_W/POC settings,
// checked every cycle against a tick-count behavioural model.
module tb_clock_gen_4201;

  localparam int NI = 5;

  function automatic int cw_of(input int i);
    case (i)
      0: return 3;
      1: return 1;
      2: return 7;
      3: return 1;
      4: return 7;
      default: return 3;
    endcase
  endfunction

  function automatic int gw_of(input int i);
    case (i)
      0: return 1;
      1: return 1;
      2: return 7;
      3: return 7;
      4: return 1;
      default: return 1;
    endcase
  endfunction

  function automatic int poc_of(input int i);
    case (i)
      0: return 64;
      1: return 5;
      2: return 3;
      3: return 2;
      4: return 4;
      default: return 64;
    endcase
  endfunction

  logic          sysclk = 1'b0;
  logic          reset;
  logic          step_mode;
  logic          step;
  logic [NI-1:0] sync_v;
  logic [NI-1:0] clk1_v;
  logic [NI-1:0] clk2_v;
  logic [NI-1:0] poc_v;
  logic [NI-1:0] halt_v;
  logic [NI-1:0] pe_v;

  int checks = 0;
  int errors = 0;
  bit sync_noise = 1'b0;

  // Behavioural model: running sysclk ticks since the last (re)start, plus flags
  int ticks      [NI];
  bit frozen     [NI];
  bit armed      [NI];
  bit poc_hi     [NI];
  int pe_count   [NI];
  int cpu_period [NI];
  bit ex_clk1    [NI];
  bit ex_clk2    [NI];
  bit ex_pe      [NI];
  bit ex_halt    [NI];
  bit prev_step;
  int since_rel;

  logic [16:0] pat_clk1 = 17'b00000111000001110;
  logic [16:0] pat_clk2 = 17'b01110000011100000;
  logic [16:0] pat_pe   = 17'b10000000100000000;

  always #5 sysclk = ~sysclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    clock_gen_4201 #(
      .CLK_W      (cw_of(g)),
      .GAP_W      (gw_of(g)),
      .POC_PERIODS(poc_of(g))
    ) u_dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .step_mode (step_mode),
      .step      (step),
      .sync      (sync_v[g]),
      .clk1_pad  (clk1_v[g]),
      .clk2_pad  (clk2_v[g]),
      .poc_pad   (poc_v[g]),
      .halted    (halt_v[g]),
      .period_end(pe_v[g])
    );
  end

  task automatic chk(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %b expected %b", name, inst, $time, act, exp);
    end
  endtask

  // Advance the model by one sysclk edge using the inputs the DUT just sampled
  task automatic model_step();
    bit rise;
    int p;
    int pos;
    bit old_pe;
    bit old_poc;
    rise = step && !prev_step;
    for (int i = 0; i < NI; i++) begin
      p = 2 * (cw_of(i) + gw_of(i));
      if (reset) begin
        ticks[i] = 0; frozen[i] = 1'b0; armed[i] = 1'b0;
        poc_hi[i] = 1'b1; pe_count[i] = 0; cpu_period[i] = 0;
        ex_clk1[i] = 1'b0; ex_clk2[i] = 1'b0; ex_pe[i] = 1'b0; ex_halt[i] = 1'b0;
      end else begin
        pos     = ticks[i] % p;
        old_pe  = ex_pe[i];
        old_poc = poc_hi[i];
        if (frozen[i]) begin
          ex_clk1[i] = 1'b0; ex_clk2[i] = 1'b0; ex_pe[i] = 1'b0; ex_halt[i] = 1'b1;
          if (rise || !step_mode) begin
            frozen[i] = 1'b0;
            ticks[i]  = 0;
          end
        end else begin
          ex_clk1[i] = pos < cw_of(i);
          ex_clk2[i] = (pos >= cw_of(i) + gw_of(i)) && (pos < 2 * cw_of(i) + gw_of(i));
          ex_pe[i]   = pos == p - 1;
          ex_halt[i] = 1'b0;
          if (pos == p - 1) cpu_period[i]++;
          if (armed[i] && !step_mode) begin
            armed[i] = 1'b0;
          end else if (armed[i] && pos == p - 1) begin
            armed[i]  = 1'b0;
            frozen[i] = 1'b1;
          end else if (!armed[i] && pos == cw_of(i) + gw_of(i) && sync_v[i] && step_mode && !old_poc) begin
            armed[i] = 1'b1;
          end
          ticks[i] = frozen[i] ? 0 : ticks[i] + 1;
        end
        if (old_pe && old_poc) begin
          pe_count[i]++;
          if (pe_count[i] == poc_of(i)) poc_hi[i] = 1'b0;
        end
      end
    end
    prev_step = reset ? 1'b1 : step;
  endtask

  // Compare process: 1 time unit after each rising edge
  initial begin
    sync_v    = '0;
    since_rel = 0;
    forever begin
      @(posedge sysclk);
      #1;
      model_step();
      since_rel = reset ? 0 : since_rel + 1;
      for (int i = 0; i < NI; i++) begin
        chk("clk1_pad", i, clk1_v[i], ex_clk1[i]);
        chk("clk2_pad", i, clk2_v[i], ex_clk2[i]);
        chk("period_end", i, pe_v[i], ex_pe[i]);
        chk("halted", i, halt_v[i], ex_halt[i]);
        chk("poc_pad", i, poc_v[i], poc_hi[i]);
        chk("overlap", i, clk1_v[i] & clk2_v[i], 1'b0);
      end
      if (since_rel <= 16) begin
        chk("pin_clk1", 0, clk1_v[0], pat_clk1[since_rel]);
        chk("pin_clk2", 0, clk2_v[0], pat_clk2[since_rel]);
        chk("pin_period_end", 0, pe_v[0], pat_pe[since_rel]);
      end
      if (since_rel == 512) chk("pin_poc_high", 0, poc_v[0], 1'b1);
      if (since_rel == 513) chk("pin_poc_low", 0, poc_v[0], 1'b0);
      // CPU-like sync: high for the whole 8th period of every run of 8
      for (int i = 0; i < NI; i++) begin
        sync_v[i] = sync_noise ? ($urandom_range(0, 3) == 0) : ((cpu_period[i] % 8) == 7);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    step_mode = 1'b0;
    step      = 1'b0;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(100);
    step_mode = 1'b1;
    wait_cyc(450);
    for (int n = 0; n < 60; n++) begin
      wait_cyc($urandom_range(10, 120));
      step = 1'b1;
      wait_cyc($urandom_range(1, 60));
      step = 1'b0;
    end
    for (int n = 0; n < 40; n++) begin
      wait_cyc($urandom_range(5, 80));
      step_mode = ($urandom_range(0, 3) != 0);
      step      = ($urandom_range(0, 1) == 1);
    end
    step_mode = 1'b0;
    step      = 1'b0;
    wait_cyc(40);
    for (int n = 0; n < 64; n++) begin
      if (!frozen[0] && (ticks[0] % 8) == 5) break;
      wait_cyc(1);
    end
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(600);
    step_mode = 1'b1;
    wait_cyc(800);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(100);
    sync_noise = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      step_mode = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) step = ~step;
      reset = ($urandom_range(0, 299) == 0);
      wait_cyc(1);
    end
    reset      = 1'b0;
    sync_noise = 1'b0;
    wait_cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_gen_4201.md
CLOCK_GEN_4201 -- requirements
Module: clock_gen_4201

Interface
REQ-001 SHALL provide parameter CLK_W, default 3: sysclk cycles each clock phase (clk1, clk2) is high; legal 1..7.
REQ-002 SHALL provide parameter GAP_W, default 1: sysclk cycles of non-overlap gap after each phase; legal 1..7.
REQ-003 SHALL provide parameter POC_PERIODS, default 64: full clock periods poc_pad stays high after reset release; legal 1..255.
REQ-004 sysclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 step_mode  in  1  1 = single-instruction-cycle stepping enabled.
REQ-007 step  in  1  step request, synchronous level; a rising edge releases one instruction cycle.
REQ-008 sync  in  1  instruction-cycle marker from the CPU sync_pad; high for one clock period per 8.
REQ-009 clk1_pad  out  1  phase-1 clock, registered.
REQ-010 clk2_pad  out  1  phase-2 clock, registered, never overlapping clk1_pad.
REQ-011 poc_pad  out  1  power-on clear to CPU, registered, active-high.
REQ-012 halted  out  1  1 while clocks are frozen in step mode.
REQ-013 period_end  out  1  one-sysclk pulse on the last sysclk of each clock period.

Function
REQ-014 Period P = 2*(CLK_W+GAP_W) sysclk; phase counter cnt counts 0..P-1, wraps to 0; default P = 8.
REQ-015 clk1_pad high for cnt in [0, CLK_W-1]; clk2_pad high for cnt in [CLK_W+GAP_W, 2*CLK_W+GAP_W-1]; both low otherwise.
REQ-016 Outputs registered: clk1_pad/clk2_pad reflect cnt of the previous sysclk cycle (1-cycle latency), no combinational path from any input.
REQ-017 clk1_pad and clk2_pad SHALL never be high in the same cycle, for every legal parameter value.
REQ-018 period_end asserts (registered, same alignment as the clocks) when cnt = P-1 and the block is running.
REQ-019 State machine: RUN, ARMED, HALT.
REQ-020 RUN: cnt advances every sysclk; sync sampled high at cnt = CLK_W+GAP_W (clk2 rising) with step_mode=1 and poc_pad=0 -> ARMED.
REQ-021 ARMED: cnt advances; at cnt = P-1 -> HALT; step_mode dropping in ARMED -> RUN, no halt.
REQ-022 HALT: cnt held at 0, clk1_pad=clk2_pad=0, halted=1, period_end=0.
REQ-023 HALT exit: step rising edge (step=1 now, registered step=0 previous cycle) -> RUN, cnt resumes from 0; step_mode=0 -> RUN.
REQ-024 step edges detected in RUN or ARMED SHALL be discarded, not queued; step held high does not re-release.
REQ-025 Step edge and step_mode falling in same HALT cycle -> single transition to RUN.
REQ-026 In HALT the first clock after release is a full CLK_W-wide clk1 pulse; no runt pulses at any transition.
REQ-027 Step mode releases exactly one instruction cycle (8 clock periods) per step edge, since sync recurs once per 8 periods.
REQ-028 POC counter (8-bit) counts period_end pulses after reset release; poc_pad drops on the sysclk after the POC_PERIODS-th period_end.
REQ-029 While poc_pad=1 the FSM SHALL stay out of ARMED/HALT so the CPU receives free-running clocks for clearing.

Reset
REQ-030 reset=1 sampled: cnt=0, state=RUN, clk1_pad=0, clk2_pad=0, period_end=0, halted=0, poc_pad=1, POC counter=0, step history=1 (prevents false edge).
REQ-031 Clocks resume from cnt=0 on the first sysclk after reset drops; reset asserted mid-period or in HALT forces REQ-030 state on the next edge, truncating any pulse.

Verification
REQ-032 Defaults, reset released at t0, step_mode=0 -> clk1_pad high sysclk t0+1..t0+3, clk2_pad high t0+5..t0+7, period 8, never overlapping.
REQ-033 POC: reset released -> poc_pad=1 through 64 period_end pulses (512 sysclk), low on following sysclk; sync high with step_mode=1 during this window causes no halt.
REQ-034 Step: step_mode=1, sync pulse at period k -> halted=1 after period k ends, clocks low; step 0->1 -> exactly 8 periods run, halt again at next sync.
REQ-035 Step pulses while RUN, and step held high across HALT entry -> no release; a fresh 0->1 edge required.
REQ-036 step_mode dropped in ARMED -> no halt; dropped in HALT -> clk1_pad rises 1 sysclk later with full 3-cycle width.
REQ-037 Reset asserted at cnt=5 (clk2 high) -> clk2_pad low next sysclk, poc_pad=1, full recovery per REQ-032; repeat sweep CLK_W,GAP_W in {1,7}.
